hazard_bypass_ctrl: RTL and testbench

- Parametrised hazard unit for the 5-stage pipeline (F/D/X/M/W).
- Generates ALU operand bypass selects, the W->M store-data bypass, and a load-use stall.
- Adds a scoreboard for the multi-cycle mult/div unit, so dependent instructions stall until the mult/div result is ready.
- Sits beside the pipeline latches. Inputs are the latched IRs plus overflow and mult/div handshakes. Outputs drive the operand muxes, PC/FD enable, and DX bubble insert.

---
 rtl/hazard_pkg.sv | 32 +++
 rtl/hazard_bypass_ctrl_if.sv | 48 ++++
 rtl/hazard_ir_decode.sv | 89 ++++++++
 rtl/hazard_bypass_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_bypass_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared decode constants, bypass-select encoding and scoreboard state for the hazard unit.
// Pure declarations: no logic and no latency of its own.
package hazard_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic [1:0] {
    SEL_XM = 2'b00,
    SEL_MW = 2'b01,
    SEL_RF = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    DRAIN = 2'b10
  } md_state_t;

endpackage

// File: rtl/hazard_bypass_ctrl_if.sv
// Pipeline-side bundle of the hazard unit: latched IRs and mult/div handshakes in, bypass/stall controls out.
// Optional stall counter signals exist only with HAZARD_STALL_COUNT_EN.
interface hazard_bypass_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [XLEN-1:0]   fd_ir;
  logic [XLEN-1:0]   dx_ir;
  logic [XLEN-1:0]   xm_ir;
  logic [XLEN-1:0]   mw_ir;
  logic              xm_ovf;
  logic              mw_ovf;
  logic              md_start;
  logic              md_ready;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              wm_sel;
  logic              stall;
  logic              bubble;
  logic              md_busy;
  logic [REG_AW-1:0] md_rd;
`ifdef HAZARD_STALL_COUNT_EN
  logic [CNT_W-1:0]  stall_count;
  logic              stall_count_clr;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

  modport master (
    output fd_ir, dx_ir, xm_ir, mw_ir, xm_ovf, mw_ovf, md_start, md_ready,
`ifdef HAZARD_STALL_COUNT_EN
    output stall_count_clr,
    input  stall_count,
`endif
    input  fwd_a_sel, fwd_b_sel, wm_sel, stall, bubble, md_busy, md_rd
  );

  modport slave (
    input  fd_ir, dx_ir, xm_ir, mw_ir, xm_ovf, mw_ovf, md_start, md_ready,
`ifdef HAZARD_STALL_COUNT_EN
    input  stall_count_clr,
    output stall_count,
`endif
    output fwd_a_sel, fwd_b_sel, wm_sel, stall, bubble, md_busy, md_rd
  );

endinterface

// File: rtl/hazard_ir_decode.sv
// Per-stage instruction decode: register sources, effective destination (overflow redirect applied) and class flags.
// Purely combinational, zero latency.
module hazard_ir_decode
  import hazard_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int OVF_REG  = 30,
  parameter int LINK_REG = 31
) (
  input  logic [XLEN-1:0]   ir,
  input  logic              ovf,
  output logic [REG_AW-1:0] src_a,
  output logic [REG_AW-1:0] src_b,
  output logic [REG_AW-1:0] dest,
  output logic              is_writer,
  output logic              is_lw,
  output logic              is_sw,
  output logic              is_md
);

  logic [4:0]        opcode;
  logic [4:0]        alu_op;
  logic [REG_AW-1:0] rd_f;
  logic [REG_AW-1:0] rs_f;
  logic [REG_AW-1:0] rt_f;
  logic              unused_bits;

  assign opcode      = ir[XLEN-1 -: 5];
  assign alu_op      = ir[6:2];
  assign rd_f        = REG_AW'(ir[26:22]);
  assign rs_f        = REG_AW'(ir[21:17]);
  assign rt_f        = REG_AW'(ir[16:12]);
  assign unused_bits = ^{ir[11:7], ir[1:0]};

  always_comb begin
    src_a     = '0;
    src_b     = '0;
    dest      = '0;
    is_writer = 1'b0;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    is_md     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        src_a     = rs_f;
        src_b     = rt_f;
        dest      = rd_f;
        is_writer = 1'b1;
        is_md     = (alu_op == ALU_MUL) || (alu_op == ALU_DIV);
      end
      OP_ADDI: begin
        src_a     = rs_f;
        dest      = rd_f;
        is_writer = 1'b1;
      end
      OP_LW: begin
        src_a     = rs_f;
        dest      = rd_f;
        is_writer = 1'b1;
        is_lw     = 1'b1;
      end
      OP_SW: begin
        src_a = rs_f;
        src_b = rd_f;
        is_sw = 1'b1;
      end
      OP_BNE, OP_BLT: begin
        src_a = rs_f;
        src_b = rd_f;
      end
      OP_JR:   src_b = rd_f;
      OP_BEX:  src_b = REG_AW'(OVF_REG);
      OP_SETX: begin
        dest      = REG_AW'(OVF_REG);
        is_writer = 1'b1;
      end
      OP_JAL: begin
        dest      = REG_AW'(LINK_REG);
        is_writer = 1'b1;
      end
      default: ;
    endcase
    // An overflowing writer lands its result in the overflow register instead.
    if (is_writer && ovf)
      dest = REG_AW'(OVF_REG);
  end

endmodule

// File: rtl/hazard_bypass_ctrl.sv
// Hazard unit for the F/D/X/M/W pipeline: zero-latency operand/store bypass selects, load-use and mult/div stalls.
// Scoreboard state is registered; HAZARD_STALL_COUNT_EN adds a saturating stall-cycle counter.
module hazard_bypass_ctrl
  import hazard_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int OVF_REG  = 30,
  parameter int LINK_REG = 31,
  parameter int CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  hazard_bypass_ctrl_if.slave hb
);

  logic [REG_AW-1:0] fd_src_a, fd_src_b, fd_dest;
  logic [REG_AW-1:0] dx_src_a, dx_src_b, dx_dest;
  logic [REG_AW-1:0] xm_src_a, xm_src_b, xm_dest;
  logic [REG_AW-1:0] mw_src_a, mw_src_b, mw_dest;
  logic fd_wr, fd_lw, fd_sw, fd_md;
  logic dx_wr, dx_lw, dx_sw, dx_md;
  logic xm_wr, xm_lw, xm_sw, xm_md;
  logic mw_wr, mw_lw, mw_sw, mw_md;

  hazard_ir_decode #(.XLEN(XLEN), .REG_AW(REG_AW), .OVF_REG(OVF_REG), .LINK_REG(LINK_REG)) u_dec_fd (
    .ir(hb.fd_ir), .ovf(1'b0), .src_a(fd_src_a), .src_b(fd_src_b), .dest(fd_dest),
    .is_writer(fd_wr), .is_lw(fd_lw), .is_sw(fd_sw), .is_md(fd_md));
  hazard_ir_decode #(.XLEN(XLEN), .REG_AW(REG_AW), .OVF_REG(OVF_REG), .LINK_REG(LINK_REG)) u_dec_dx (
    .ir(hb.dx_ir), .ovf(1'b0), .src_a(dx_src_a), .src_b(dx_src_b), .dest(dx_dest),
    .is_writer(dx_wr), .is_lw(dx_lw), .is_sw(dx_sw), .is_md(dx_md));
  hazard_ir_decode #(.XLEN(XLEN), .REG_AW(REG_AW), .OVF_REG(OVF_REG), .LINK_REG(LINK_REG)) u_dec_xm (
    .ir(hb.xm_ir), .ovf(hb.xm_ovf), .src_a(xm_src_a), .src_b(xm_src_b), .dest(xm_dest),
    .is_writer(xm_wr), .is_lw(xm_lw), .is_sw(xm_sw), .is_md(xm_md));
  hazard_ir_decode #(.XLEN(XLEN), .REG_AW(REG_AW), .OVF_REG(OVF_REG), .LINK_REG(LINK_REG)) u_dec_mw (
    .ir(hb.mw_ir), .ovf(hb.mw_ovf), .src_a(mw_src_a), .src_b(mw_src_b), .dest(mw_dest),
    .is_writer(mw_wr), .is_lw(mw_lw), .is_sw(mw_sw), .is_md(mw_md));

  logic unused_dec;
  assign unused_dec = ^{fd_lw, fd_sw, dx_wr, dx_sw, dx_md, xm_src_a, xm_lw, xm_md,
                        mw_src_a, mw_src_b, mw_lw, mw_sw, mw_md};

  logic xm_live, mw_live;
  assign xm_live = xm_wr && (xm_dest != '0);
  assign mw_live = mw_wr && (mw_dest != '0);

  fwd_sel_t fwd_a, fwd_b;

  always_comb begin
    fwd_a = SEL_RF;
    fwd_b = SEL_RF;
    if (!reset) begin
      if (xm_live && xm_dest == dx_src_a)      fwd_a = SEL_XM;
      else if (mw_live && mw_dest == dx_src_a) fwd_a = SEL_MW;
      if (xm_live && xm_dest == dx_src_b)      fwd_b = SEL_XM;
      else if (mw_live && mw_dest == dx_src_b) fwd_b = SEL_MW;
    end
  end

  md_state_t         state;
  logic [REG_AW-1:0] md_rd_q;
  logic              md_busy_q;
  logic              load_use, sb_hit, stall_int;

  assign load_use = dx_lw && (dx_dest != '0) &&
                    (dx_dest == fd_src_a || dx_dest == fd_src_b);

  // RAW on either source, WAW on the destination, or a second mult/div wanting the unit.
  assign sb_hit = (state == BUSY) &&
                  (fd_md || ((md_rd_q != '0) &&
                   (fd_src_a == md_rd_q || fd_src_b == md_rd_q || (fd_wr && fd_dest == md_rd_q))));

  assign stall_int = !reset && (load_use || sb_hit);

  assign hb.fwd_a_sel = fwd_a;
  assign hb.fwd_b_sel = fwd_b;
  assign hb.wm_sel    = !reset && xm_sw && mw_live && (xm_src_b == mw_dest);
  assign hb.stall     = stall_int;
  assign hb.bubble    = stall_int;
  assign hb.md_busy   = md_busy_q;
  assign hb.md_rd     = md_rd_q;

  // A new issue always takes the unit, even when it coincides with the old result arriving.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      md_rd_q   <= '0;
      md_busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (hb.md_start) begin
          state     <= BUSY;
          md_rd_q   <= dx_dest;
          md_busy_q <= 1'b1;
        end
        BUSY: if (hb.md_start) begin
          md_rd_q <= dx_dest;
        end else if (hb.md_ready) begin
          state     <= DRAIN;
          md_busy_q <= 1'b0;
        end
        DRAIN: if (hb.md_start) begin
          state     <= BUSY;
          md_rd_q   <= dx_dest;
          md_busy_q <= 1'b1;
        end else begin
          state   <= IDLE;
          md_rd_q <= '0;
        end
        default: begin
          state     <= IDLE;
          md_rd_q   <= '0;
          md_busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clock) begin
    if (reset || hb.stall_count_clr)
      stall_cnt <= '0;
    else if (stall_int && stall_cnt != {CNT_W{1'b1}})
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign hb.stall_count = stall_cnt;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_hazard_bypass_ctrl.sv
// Bench for hazard_bypass_ctrl: directed pipeline scenarios plus randomized IR streams against a rule-level model.
module tb_hazard_bypass_ctrl;

`ifdef HAZARD_STALL_COUNT_EN
  localparam int TB_CNT_W = 2;
`else
  localparam int TB_CNT_W = 16;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hazard_bypass_ctrl_if #(.XLEN(32), .REG_AW(5), .CNT_W(TB_CNT_W)) hb ();

  hazard_bypass_ctrl #(.XLEN(32), .REG_AW(5), .OVF_REG(30), .LINK_REG(31), .CNT_W(TB_CNT_W)) dut (
    .clock(clock),
    .reset(reset),
    .hb(hb)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction builders ----------------
  localparam logic [31:0] NOP = 32'h0;

  function automatic logic [31:0] rins(input int rd, input int rs, input int rt, input int alu);
    return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(alu), 2'b00};
  endfunction

  function automatic logic [31:0] iins(input int op, input int rd, input int rs, input int imm);
    return {5'(op), 5'(rd), 5'(rs), 17'(imm)};
  endfunction

  function automatic logic [31:0] jins(input int op, input int tgt);
    return {5'(op), 27'(tgt)};
  endfunction

  // ---------------- rule-level model ----------------
  typedef struct {
    int a;    // -1 = no register read
    int b;
    int dst;  // 0 for non-writers
    bit wr;
    bit lw;
    bit sw;
    bit md;
  } dec_t;

  function automatic dec_t dec(input logic [31:0] ir, input logic ovf);
    dec_t d;
    int op, rd, rs, rt, alu;
    op  = int'(ir[31:27]);
    rd  = int'(ir[26:22]);
    rs  = int'(ir[21:17]);
    rt  = int'(ir[16:12]);
    alu = int'(ir[6:2]);
    d = '{a: -1, b: -1, dst: 0, wr: 0, lw: 0, sw: 0, md: 0};
    case (op)
      0:  begin d.a = rs; d.b = rt; d.dst = rd; d.wr = 1; d.md = (alu == 6 || alu == 7); end
      5:  begin d.a = rs; d.dst = rd; d.wr = 1; end
      8:  begin d.a = rs; d.dst = rd; d.wr = 1; d.lw = 1; end
      7:  begin d.a = rs; d.b = rd; d.sw = 1; end
      2, 6: begin d.a = rs; d.b = rd; end
      4:  d.b = rd;
      22: d.b = 30;
      21: begin d.dst = 30; d.wr = 1; end
      3:  begin d.dst = 31; d.wr = 1; end
      default: ;
    endcase
    if (d.wr && ovf) d.dst = 30;
    return d;
  endfunction

  int busy_rd  = -1;  // destination of the in-flight mult/div, -1 when none
  bit draining = 0;
  int drain_rd = 0;
  int cnt      = 0;
  bit started  = 0;

  function automatic int fwd_of(input int src, input dec_t x, input dec_t m);
    if (x.wr && x.dst != 0 && x.dst == src) return 0;
    if (m.wr && m.dst != 0 && m.dst == src) return 1;
    return 2;
  endfunction

  function automatic void expect_comb(output int fa, output int fb, output int wm, output int st);
    dec_t f, d, x, m;
    bit lu, sb;
    f = dec(hb.fd_ir, 1'b0);
    d = dec(hb.dx_ir, 1'b0);
    x = dec(hb.xm_ir, hb.xm_ovf);
    m = dec(hb.mw_ir, hb.mw_ovf);
    lu = d.lw && d.dst != 0 && (d.dst == f.a || d.dst == f.b);
    sb = (busy_rd >= 0) &&
         (f.md || (busy_rd != 0 && (f.a == busy_rd || f.b == busy_rd || (f.wr && f.dst == busy_rd))));
    if (reset) begin
      fa = 2; fb = 2; wm = 0; st = 0;
    end else begin
      fa = fwd_of(d.a, x, m);
      fb = fwd_of(d.b, x, m);
      wm = (x.sw && m.wr && m.dst != 0 && int'(hb.xm_ir[26:22]) == m.dst) ? 1 : 0;
      st = (lu || sb) ? 1 : 0;
    end
  endfunction

  always @(posedge clock) begin
    int fa, fb, wm, st, nd;
    expect_comb(fa, fb, wm, st);
    nd = dec(hb.dx_ir, 1'b0).dst;
`ifdef HAZARD_STALL_COUNT_EN
    if (reset || hb.stall_count_clr) cnt = 0;
    else if (st == 1 && cnt < (1 << TB_CNT_W) - 1) cnt = cnt + 1;
`endif
    if (reset) begin
      busy_rd = -1; draining = 0; drain_rd = 0;
    end else if (hb.md_start) begin
      busy_rd = nd; draining = 0;
    end else if (busy_rd >= 0 && hb.md_ready) begin
      drain_rd = busy_rd; busy_rd = -1; draining = 1;
    end else if (draining) begin
      draining = 0; drain_rd = 0;
    end
    started = 1;
  end

  always @(negedge clock) begin
    int fa, fb, wm, st;
    if (started) begin
      expect_comb(fa, fb, wm, st);
      chk("fwd_a_sel", int'(hb.fwd_a_sel), fa);
      chk("fwd_b_sel", int'(hb.fwd_b_sel), fb);
      chk("wm_sel", int'(hb.wm_sel), wm);
      chk("stall", int'(hb.stall), st);
      chk("bubble", int'(hb.bubble), st);
      chk("md_busy", int'(hb.md_busy), (busy_rd >= 0) ? 1 : 0);
      chk("md_rd", int'(hb.md_rd), (busy_rd >= 0) ? busy_rd : (draining ? drain_rd : 0));
`ifdef HAZARD_STALL_COUNT_EN
      chk("stall_count", int'(hb.stall_count), cnt);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [31:0] fd, input logic [31:0] dx, input logic [31:0] xm,
                       input logic [31:0] mw, input logic xo, input logic mo,
                       input logic st, input logic rdy);
    hb.fd_ir = fd; hb.dx_ir = dx; hb.xm_ir = xm; hb.mw_ir = mw;
    hb.xm_ovf = xo; hb.mw_ovf = mo; hb.md_start = st; hb.md_ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  int pool[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 30, 31};

  function automatic int pr();
    return pool[$urandom_range(0, 9)];
  endfunction

  function automatic logic [31:0] rand_ins();
    case ($urandom_range(0, 11))
      0, 1: return rins(pr(), pr(), pr(), $urandom_range(0, 7));
      2:  return iins(5, pr(), pr(), $urandom_range(0, 255));
      3:  return iins(8, pr(), pr(), $urandom_range(0, 255));
      4:  return iins(7, pr(), pr(), $urandom_range(0, 255));
      5:  return iins(2, pr(), pr(), $urandom_range(0, 255));
      6:  return iins(6, pr(), pr(), $urandom_range(0, 255));
      7:  return iins(4, pr(), 0, 0);
      8:  return jins(1, $urandom_range(0, 1000));
      9:  return jins(3, $urandom_range(0, 1000));
      10: return jins(21, $urandom_range(0, 1000));
      default: return jins(22, $urandom_range(0, 1000));
    endcase
  endfunction

  initial begin
    int n;
    reset = 1'b1;
`ifdef HAZARD_STALL_COUNT_EN
    hb.stall_count_clr = 1'b0;
`endif
    // reset masks a live load-use and an XM bypass
    drive(rins(6, 5, 2, 0), iins(8, 5, 1, 0), rins(1, 2, 3, 0), NOP, 0, 0, 0, 0);
    next_cycle();
    @(negedge clock);
    chk("rst_stall", int'(hb.stall), 0);
    chk("rst_fwd_a", int'(hb.fwd_a_sel), 2);
    chk("rst_md_busy", int'(hb.md_busy), 0);
    chk("rst_md_rd", int'(hb.md_rd), 0);
    next_cycle();
    reset = 1'b0;

    drive(NOP, rins(4, 3, 3, 0), rins(3, 1, 2, 0), NOP, 0, 0, 0, 0);
    @(negedge clock);
    chk("xm_fwd_a", int'(hb.fwd_a_sel), 0);
    chk("xm_fwd_b", int'(hb.fwd_b_sel), 0);
    next_cycle();
    drive(NOP, rins(4, 3, 3, 0), NOP, rins(3, 1, 2, 0), 0, 0, 0, 0);
    @(negedge clock);
    chk("mw_fwd_a", int'(hb.fwd_a_sel), 1);
    chk("mw_fwd_b", int'(hb.fwd_b_sel), 1);
    next_cycle();
    drive(NOP, rins(4, 0, 0, 0), NOP, rins(0, 1, 2, 0), 0, 0, 0, 0);
    @(negedge clock);
    chk("r0_fwd_a", int'(hb.fwd_a_sel), 2);
    chk("r0_fwd_b", int'(hb.fwd_b_sel), 2);
    next_cycle();

    drive(rins(6, 5, 2, 0), iins(8, 5, 1, 0), NOP, NOP, 0, 0, 0, 0);
    @(negedge clock);
    chk("lu_stall", int'(hb.stall), 1);
    chk("lu_bubble", int'(hb.bubble), 1);
    next_cycle();
    drive(NOP, rins(6, 5, 2, 0), iins(8, 5, 1, 0), NOP, 0, 0, 0, 0);
    @(negedge clock);
    chk("lu_after_fwd_a", int'(hb.fwd_a_sel), 0);
    chk("lu_after_stall", int'(hb.stall), 0);
    next_cycle();

    // mul r7 with a dependent add waiting in FD for 32 cycles
    drive(rins(8, 7, 0, 0), rins(7, 1, 2, 6), NOP, NOP, 0, 0, 1, 0);
    @(negedge clock);
    chk("md_issue_stall", int'(hb.stall), 0);
    next_cycle();
    n = 0;
    for (int i = 0; i < 32; i++) begin
      drive(rins(8, 7, 0, 0), NOP, NOP, NOP, 0, 0, 0, (i == 31) ? 1'b1 : 1'b0);
      @(negedge clock);
      if (hb.stall === 1'b1) n++;
      next_cycle();
    end
    chk("md_stall_cycles", n, 32);
    drive(rins(8, 7, 0, 0), NOP, NOP, NOP, 0, 0, 0, 0);
    @(negedge clock);
    chk("drain_busy", int'(hb.md_busy), 0);
    chk("drain_stall", int'(hb.stall), 0);
    next_cycle();
    @(negedge clock);
    chk("idle_md_rd", int'(hb.md_rd), 0);
    next_cycle();

    // ready and a new issue together: the new op keeps the unit
    drive(NOP, rins(7, 1, 2, 6), NOP, NOP, 0, 0, 1, 0);
    next_cycle();
    drive(NOP, rins(9, 1, 2, 7), NOP, NOP, 0, 0, 1, 1);
    next_cycle();
    drive(rins(10, 9, 1, 0), NOP, NOP, NOP, 0, 0, 0, 1);
    @(negedge clock);
    chk("renew_busy", int'(hb.md_busy), 1);
    chk("renew_md_rd", int'(hb.md_rd), 9);
    chk("renew_stall", int'(hb.stall), 1);
    next_cycle();
    drive(NOP, NOP, NOP, NOP, 0, 0, 0, 0);
    next_cycle();
    next_cycle();

    drive(NOP, jins(22, 0), rins(3, 1, 2, 0), NOP, 1, 0, 0, 0);
    @(negedge clock);
    chk("bex_ovf_fwd_b", int'(hb.fwd_b_sel), 0);
    next_cycle();
    drive(NOP, jins(22, 0), rins(3, 1, 2, 0), NOP, 0, 0, 0, 0);
    @(negedge clock);
    chk("bex_noovf_fwd_b", int'(hb.fwd_b_sel), 2);
    next_cycle();
    drive(NOP, NOP, iins(7, 4, 1, 0), iins(5, 4, 1, 5), 0, 0, 0, 0);
    @(negedge clock);
    chk("wm_sel_hit", int'(hb.wm_sel), 1);
    next_cycle();
    drive(NOP, NOP, iins(7, 4, 1, 0), iins(5, 4, 1, 5), 0, 1, 0, 0);
    @(negedge clock);
    chk("wm_sel_ovf", int'(hb.wm_sel), 0);
    next_cycle();

    // reset arriving while a mult/div is outstanding
    drive(NOP, rins(7, 1, 2, 6), NOP, NOP, 0, 0, 1, 0);
    next_cycle();
    drive(rins(8, 7, 0, 0), NOP, NOP, NOP, 0, 0, 0, 0);
    @(negedge clock);
    chk("pre_rst_stall", int'(hb.stall), 1);
    next_cycle();
    reset = 1'b1;
    @(negedge clock);
    chk("in_rst_stall", int'(hb.stall), 0);
    next_cycle();
    reset = 1'b0;
    hb.md_ready = 1'b1;
    @(negedge clock);
    chk("post_rst_busy", int'(hb.md_busy), 0);
    chk("post_rst_stall", int'(hb.stall), 0);
    next_cycle();
    hb.md_ready = 1'b0;
    @(negedge clock);
    chk("late_ready_busy", int'(hb.md_busy), 0);
    chk("late_ready_rd", int'(hb.md_rd), 0);
    next_cycle();

`ifdef HAZARD_STALL_COUNT_EN
    drive(rins(6, 5, 2, 0), iins(8, 5, 1, 0), NOP, NOP, 0, 0, 0, 0);
    hb.stall_count_clr = 1'b1;
    next_cycle();
    hb.stall_count_clr = 1'b0;
    repeat (5) next_cycle();
    drive(NOP, NOP, NOP, NOP, 0, 0, 0, 0);
    @(negedge clock);
    chk("cnt_saturate", int'(hb.stall_count), 3);
    next_cycle();
    hb.stall_count_clr = 1'b1;
    next_cycle();
    hb.stall_count_clr = 1'b0;
    @(negedge clock);
    chk("cnt_clear", int'(hb.stall_count), 0);
    next_cycle();
`endif

    for (int i = 0; i < 4000; i++) begin
      drive(rand_ins(), rand_ins(), rand_ins(), rand_ins(),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
      reset = ($urandom_range(0, 99) == 0);
`ifdef HAZARD_STALL_COUNT_EN
      hb.stall_count_clr = ($urandom_range(0, 49) == 0);
`endif
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
